// File: rtl/led_strip_pkg.sv
// led_strip_pkg: shared FSM state type, 12 MHz timing defaults and helpers for the LED strip driver
package led_strip_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_e;

    localparam int DEF_LED_COUNT    = 60;
    localparam int DEF_BITS_PER_LED = 24;
    localparam int DEF_BIT_CYCLES   = 15;
    localparam int DEF_T0H_CYCLES   = 5;
    localparam int DEF_T1H_CYCLES   = 10;
    localparam int DEF_LATCH_CYCLES = 1000;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // c*(b+1)>>8 so that b=255 passes the channel through unchanged
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        return 8'(({8'd0, c} * ({8'd0, b} + 16'd1)) >> 8);
    endfunction

endpackage

// File: rtl/led_bit_encoder.sv
// led_bit_encoder: turns one data bit into a fixed-length high/low pulse window
module led_bit_encoder
    import led_strip_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic bit_i,
    output logic level_o,
    output logic bit_done_o
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic          active_q, active_d;
    logic          bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_done_o = active_q && (cnt_q == CW'(BIT_CYCLES - 1));
    assign level_o    = active_q && (cnt_q < (bit_q ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)));

    // a start in the last cycle of a window opens the next window without a gap
    always_comb begin
        active_d = start_i ? 1'b1 : (active_q && !bit_done_o);
        bit_d    = start_i ? bit_i : bit_q;
        cnt_d    = start_i ? '0 : (active_q ? cnt_q + 1'b1 : cnt_q);
    end

    // window state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            bit_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/led_strip_driver.sv
// led_strip_driver: streams a frame of pixels with one-pixel prefetch to an xx6812 strip; LED_STRIP_BRIGHTNESS_EN adds brightness scaling
module led_strip_driver
    import led_strip_pkg::*;
#(
    parameter int LED_COUNT    = DEF_LED_COUNT,
    parameter int BITS_PER_LED = DEF_BITS_PER_LED,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int ADDR_W       = addr_width(LED_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start_i,
    output logic                    pixel_req_o,
    output logic [ADDR_W-1:0]       pixel_addr_o,
    input  logic                    pixel_valid_i,
    input  logic [BITS_PER_LED-1:0] pixel_data_i,
    output logic                    serial_out_o,
    output logic                    busy_o,
    output logic                    frame_done_o,
    output logic                    underrun_o
`ifdef LED_STRIP_BRIGHTNESS_EN
   ,input  logic [7:0]              brightness_i
`endif
);

    localparam int CMAX = (BIT_CYCLES > LATCH_CYCLES) ? BIT_CYCLES : LATCH_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = $clog2(BITS_PER_LED);
    localparam int MSB  = BITS_PER_LED - 1;
    localparam logic [ADDR_W:0] LED_LAST   = (ADDR_W + 1)'(LED_COUNT - 1);
    localparam logic [BW-1:0]   BIT_LAST   = BW'(BITS_PER_LED - 1);
    localparam logic [CW-1:0]   LATCH_LAST = CW'(LATCH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [MSB:0]      shreg_q, shreg_d;
    logic [MSB:0]      buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [ADDR_W:0]   led_cnt_q, led_cnt_d;
    logic [CW-1:0]     lcnt_q, lcnt_d;
    logic              pend_q, pend_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              underrun_q, underrun_d;
    logic [MSB:0]      px_s, nxt;
    logic              acc, enc_start, enc_bit, enc_done, enc_level;

    // a pixel_valid counts only while a request is outstanding, including its own request cycle
    assign acc = pixel_valid_i && (req_q || pend_q);
    assign nxt = buf_full_q ? buf_q : px_s;

`ifdef LED_STRIP_BRIGHTNESS_EN
    // scale each 8-bit channel at capture time
    always_comb begin
        px_s = pixel_data_i;
        for (int i = 0; i < BITS_PER_LED / 8; i++) px_s[i*8 +: 8] = scale8(pixel_data_i[i*8 +: 8], brightness_i);
    end
`else
    assign px_s = pixel_data_i;
`endif

    led_bit_encoder #(
        .BIT_CYCLES(BIT_CYCLES),
        .T0H_CYCLES(T0H_CYCLES),
        .T1H_CYCLES(T1H_CYCLES)
    ) u_enc (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (enc_start),
        .bit_i     (enc_bit),
        .level_o   (enc_level),
        .bit_done_o(enc_done)
    );

    assign serial_out_o = enc_level;
    assign pixel_req_o  = req_q;
    assign pixel_addr_o = addr_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;
    assign underrun_o   = underrun_q;

    // frame sequencing, prefetch handshake and bit scheduling
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        bit_cnt_d  = bit_cnt_q;
        led_cnt_d  = led_cnt_q;
        lcnt_d     = lcnt_q;
        pend_d     = (pend_q || req_q) && !acc;
        req_d      = 1'b0;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        enc_start  = 1'b0;
        enc_bit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start_i && !done_q) begin
                    busy_d     = 1'b1;
                    underrun_d = 1'b0;
                    req_d      = 1'b1;
                    addr_d     = '0;
                    led_cnt_d  = '0;
                    buf_full_d = 1'b0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (acc) begin
                    enc_start = 1'b1;
                    enc_bit   = px_s[MSB];
                    shreg_d   = px_s << 1;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                    if (led_cnt_q != LED_LAST) begin
                        req_d  = 1'b1;
                        addr_d = ADDR_W'(led_cnt_q + 1'b1);
                    end
                end
            end
            SHIFT: begin
                if (acc) begin
                    buf_d      = px_s;
                    buf_full_d = 1'b1;
                end
                if (enc_done) begin
                    if (bit_cnt_q != BIT_LAST) begin
                        enc_start = 1'b1;
                        enc_bit   = shreg_q[MSB];
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (led_cnt_q == LED_LAST) begin
                        lcnt_d  = '0;
                        state_d = LATCH;
                    end else if (buf_full_q || acc) begin
                        enc_start  = 1'b1;
                        enc_bit    = nxt[MSB];
                        shreg_d    = nxt << 1;
                        bit_cnt_d  = '0;
                        buf_full_d = 1'b0;
                        led_cnt_d  = led_cnt_q + 1'b1;
                        if (led_cnt_q + 1'b1 != LED_LAST) begin
                            req_d  = 1'b1;
                            addr_d = ADDR_W'(led_cnt_q + 2'd2);
                        end
                    end else begin
                        underrun_d = 1'b1;
                        pend_d     = 1'b0;
                        lcnt_d     = '0;
                        state_d    = LATCH;
                    end
                end
            end
            LATCH: begin
                lcnt_d = lcnt_q + 1'b1;
                if (lcnt_q == LATCH_LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            bit_cnt_q  <= '0;
            led_cnt_q  <= '0;
            lcnt_q     <= '0;
            pend_q     <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            bit_cnt_q  <= bit_cnt_d;
            led_cnt_q  <= led_cnt_d;
            lcnt_q     <= lcnt_d;
            pend_q     <= pend_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_led_strip_driver.sv
// tb_led_strip_driver: scoreboard bench decoding the strip waveform for a 2-LED driver
module tb_led_strip_driver;

    localparam int LC  = 2;
    localparam int BPL = 24;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           frame_start = 1'b0;
    logic           pixel_valid = 1'b0;
    logic [BPL-1:0] pixel_data = '0;
    logic [7:0]     brightness = 8'd255;
    logic           pixel_req, serial_out, busy, frame_done, underrun;
    logic [0:0]     pixel_addr;

    always #5 clk = ~clk;

    led_strip_driver #(.LED_COUNT(LC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start_i(frame_start),
        .pixel_req_o  (pixel_req),
        .pixel_addr_o (pixel_addr),
        .pixel_valid_i(pixel_valid),
        .pixel_data_i (pixel_data),
        .serial_out_o (serial_out),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .underrun_o   (underrun)
`ifdef LED_STRIP_BRIGHTNESS_EN
       ,.brightness_i (brightness)
`endif
    );

    int n_tests = 0, n_fail = 0;
    logic [BPL-1:0] pix [LC];
    bit  withhold [LC];
    int  src_lat = 0, req_count = 0, rcnt = -1, rcur = 0;
    int  req_addr_q[$], exp_hi[$], obs_hi[$], rise_q[$], done_q[$];
    int  cyc = 0, hi_cnt = 0;
    logic prev = 1'b0;

    // pixel source: answers src_lat cycles after each request unless that pixel is withheld
    always @(negedge clk) begin
        if (!rst_n) begin
            rcnt = -1;
            pixel_valid = 1'b0;
        end else begin
            pixel_valid = 1'b0;
            if (pixel_req) begin
                req_count++;
                req_addr_q.push_back(int'(pixel_addr));
                rcur = int'(pixel_addr);
                rcnt = src_lat;
            end else if (rcnt > 0) rcnt--;
            if (rcnt == 0) begin
                if (!withhold[rcur]) begin
                    pixel_valid = 1'b1;
                    pixel_data = pix[rcur];
                end
                rcnt = -1;
            end
        end
    end

    // strip monitor: high-time of each pulse, cycle of each rise and of each frame_done
    always @(negedge clk) begin
        cyc++;
        if (serial_out) hi_cnt++;
        else if (prev) begin
            obs_hi.push_back(hi_cnt);
            hi_cnt = 0;
        end
        if (serial_out && !prev) rise_q.push_back(cyc);
        if (frame_done) done_q.push_back(cyc);
        prev = serial_out;
    end

    task automatic clear_sb();
        exp_hi.delete(); obs_hi.delete(); rise_q.delete(); done_q.delete(); req_addr_q.delete();
        req_count = 0;
    endtask

    task automatic push_pixel(input logic [BPL-1:0] p);
        for (int b = BPL - 1; b >= 0; b--) exp_hi.push_back(p[b] ? 10 : 5);
    endtask

    task automatic start_frame();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frame_done) begin ok = 1'b1; break; end
        end
    endtask

    function automatic int gap_errors();
        int g = 0;
        for (int i = 1; i < rise_q.size(); i++) if (rise_q[i] - rise_q[i-1] != 15) g++;
        return g;
    endfunction

    function automatic int latch_len();
        return (done_q.size() == 1 && rise_q.size() > 0) ? done_q[0] - rise_q[$] : -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({serial_out, busy, pixel_req, pixel_addr, frame_done, underrun} !== 6'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 000000", {serial_out, busy, pixel_req, pixel_addr, frame_done, underrun});
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({busy, pixel_req, serial_out} !== 3'b0) begin
            n_fail++; $display("FAIL reset_idle: busy/req/serial %b want 000", {busy, pixel_req, serial_out});
        end
    endtask

    task automatic test_frame();
        bit ok;
        int e, o;
        clear_sb(); src_lat = 0;
        pix[0] = 24'h800000; pix[1] = 24'h000001;
        push_pixel(pix[0]); push_pixel(pix[1]);
        start_frame(); wait_done(ok); repeat (3) @(negedge clk);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL frame_timeout: frame_done never seen"); end
        n_tests++; if (obs_hi.size() !== 48) begin n_fail++; $display("FAIL frame_bits: got %0d pulses want 48", obs_hi.size()); end
        while (exp_hi.size() > 0 && obs_hi.size() > 0) begin
            e = exp_hi.pop_front(); o = obs_hi.pop_front();
            n_tests++; if (o !== e) begin n_fail++; $display("FAIL frame_high: got %0d cycles want %0d", o, e); end
        end
        n_tests++; if (gap_errors() !== 0) begin n_fail++; $display("FAIL frame_gap: %0d non-15 bit spacings want 0", gap_errors()); end
        n_tests++; if (latch_len() !== 1015) begin n_fail++; $display("FAIL frame_latch: last rise to done %0d want 1015", latch_len()); end
        n_tests++; if ({busy, underrun} !== 2'b00) begin n_fail++; $display("FAIL frame_end: busy/underrun %b want 00", {busy, underrun}); end
    endtask

    task automatic test_slow_source();
        bit ok;
        int e, o, bad = 0;
        clear_sb(); src_lat = 3;
        pix[0] = BPL'($urandom); pix[1] = BPL'($urandom);
        push_pixel(pix[0]); push_pixel(pix[1]);
        start_frame(); wait_done(ok); repeat (3) @(negedge clk);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL slow_timeout: frame_done never seen"); end
        while (exp_hi.size() > 0 && obs_hi.size() > 0) begin
            e = exp_hi.pop_front(); o = obs_hi.pop_front();
            if (o !== e) bad++;
        end
        n_tests++; if (bad !== 0 || exp_hi.size() !== 0 || obs_hi.size() !== 0) begin
            n_fail++; $display("FAIL slow_bits: %0d wrong pulses, %0d/%0d left want 0", bad, exp_hi.size(), obs_hi.size());
        end
        n_tests++; if (gap_errors() !== 0 || rise_q.size() !== 48) begin
            n_fail++; $display("FAIL slow_gap: %0d gaps over %0d rises want 0 over 48", gap_errors(), rise_q.size());
        end
        n_tests++; if (req_addr_q.size() !== 2 || req_addr_q[0] !== 0 || req_addr_q[1] !== 1) begin
            n_fail++; $display("FAIL slow_addr: %0d requests, addrs %p want 0,1", req_addr_q.size(), req_addr_q);
        end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL slow_underrun: got %b want 0", underrun); end
        src_lat = 0;
    endtask

    task automatic test_underrun();
        bit ok;
        int e, o, bad = 0;
        clear_sb(); withhold[1] = 1'b1;
        pix[0] = BPL'($urandom); pix[1] = BPL'($urandom);
        push_pixel(pix[0]);
        start_frame(); wait_done(ok); repeat (3) @(negedge clk);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL underrun_timeout: frame_done never seen"); end
        while (exp_hi.size() > 0 && obs_hi.size() > 0) begin
            e = exp_hi.pop_front(); o = obs_hi.pop_front();
            if (o !== e) bad++;
        end
        n_tests++; if (bad !== 0 || rise_q.size() !== 24) begin
            n_fail++; $display("FAIL underrun_bits: %0d wrong, %0d rises want 0 wrong, 24 rises", bad, rise_q.size());
        end
        n_tests++; if (latch_len() !== 1015) begin n_fail++; $display("FAIL underrun_latch: last rise to done %0d want 1015", latch_len()); end
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_flag: got %b want 1", underrun); end
        withhold[1] = 1'b0;
        clear_sb(); push_pixel(pix[0]); push_pixel(pix[1]);
        start_frame();
        n_tests++; if ({busy, underrun} !== 2'b10) begin n_fail++; $display("FAIL underrun_clear: busy/underrun %b want 10", {busy, underrun}); end
        wait_done(ok); repeat (3) @(negedge clk);
        n_tests++; if (!ok || obs_hi.size() !== 48 || underrun !== 1'b0) begin
            n_fail++; $display("FAIL underrun_recover: done %b pulses %0d underrun %b want 1 48 0", ok, obs_hi.size(), underrun);
        end
    endtask

    task automatic test_ignore_start();
        bit ok;
        int e, o, bad = 0;
        clear_sb();
        pix[0] = BPL'($urandom); pix[1] = BPL'($urandom);
        push_pixel(pix[0]); push_pixel(pix[1]);
        start_frame();
        repeat (100) @(negedge clk);
        frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
        wait_done(ok);
        frame_start = 1'b1; @(negedge clk); frame_start = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ignore_timeout: frame_done never seen"); end
        n_tests++; if (req_count !== 2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ignore_restart: %0d requests busy %b want 2 requests busy 0", req_count, busy);
        end
        while (exp_hi.size() > 0 && obs_hi.size() > 0) begin
            e = exp_hi.pop_front(); o = obs_hi.pop_front();
            if (o !== e) bad++;
        end
        n_tests++; if (bad !== 0 || rise_q.size() !== 48 || done_q.size() !== 1) begin
            n_fail++; $display("FAIL ignore_frame: %0d wrong, %0d rises, %0d dones want 0 48 1", bad, rise_q.size(), done_q.size());
        end
    endtask

    task automatic test_async_reset();
        bit ok = 1'b0;
        clear_sb();
        pix[0] = 24'hFFFFFF; pix[1] = 24'hFFFFFF;
        start_frame();
        repeat (100) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (serial_out) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (!ok || {serial_out, busy, pixel_req} !== 3'b000) begin
            n_fail++; $display("FAIL async_reset: high seen %b, serial/busy/req %b want 1 000", ok, {serial_out, busy, pixel_req});
        end
        repeat (2) @(negedge clk);
        clear_sb(); hi_cnt = 0; prev = 1'b0;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_tests++; if (busy !== 1'b0 || rise_q.size() !== 0 || req_count !== 0) begin
            n_fail++; $display("FAIL reset_release: busy %b rises %0d reqs %0d want 0 0 0", busy, rise_q.size(), req_count);
        end
        start_frame(); wait_done(ok); repeat (3) @(negedge clk);
        n_tests++; if (!ok || obs_hi.size() !== 48) begin
            n_fail++; $display("FAIL reset_restart: done %b pulses %0d want 1 48", ok, obs_hi.size());
        end
    endtask

`ifdef LED_STRIP_BRIGHTNESS_EN
    task automatic test_brightness();
        bit ok;
        int e, o, bad = 0;
        clear_sb(); brightness = 8'd127;
        pix[0] = 24'hFF80FF; pix[1] = 24'hFF80FF;
        push_pixel(24'h7F407F); push_pixel(24'h7F407F);
        start_frame(); wait_done(ok); repeat (3) @(negedge clk);
        while (exp_hi.size() > 0 && obs_hi.size() > 0) begin
            e = exp_hi.pop_front(); o = obs_hi.pop_front();
            if (o !== e) bad++;
        end
        n_tests++; if (!ok || bad !== 0 || rise_q.size() !== 48) begin
            n_fail++; $display("FAIL brightness: done %b, %0d wrong, %0d rises want 1 0 48", ok, bad, rise_q.size());
        end
        brightness = 8'd255;
    endtask
`endif

    initial begin
        withhold[0] = 1'b0; withhold[1] = 1'b0;
        pix[0] = '0; pix[1] = '0;
        test_reset();
        test_frame();
        test_slow_source();
        test_underrun();
        test_ignore_start();
        test_async_reset();
`ifdef LED_STRIP_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
